// File: rtl/imem_loader_if.sv
// Instruction-RAM write port: the loader drives it, the RAM/fetch side receives it.
interface imem_loader_if;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;

    modport master (output imem_we, imem_addr, imem_wdata);
    modport slave  (input  imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_loader.sv
// UART (8N1) program loader: SYNC/LEN/data/CSUM frame -> 32-bit instruction RAM writes, core held meanwhile.
// Write strobe 1 cycle after a word's last byte completes; no backpressure, the RAM must accept every write.
module imem_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int MAX_WORDS    = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx,
    imem_loader_if.master imem,
    output logic          core_hold,
    output logic          done,
    output logic          err
);
    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [7:0]    SYNC     = 8'hA5;
    localparam logic [7:0]    LEN_MAX  = 8'(MAX_WORDS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {WAIT_SYNC, GET_LEN, GET_DATA, GET_CSUM} frm_state_t;

    logic rx_meta, rx_s, rx_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    rx_state_t     rx_state, rx_state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          byte_vld, byte_ferr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            rx_state <= rx_state_nxt;
            cnt      <= cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            shreg    <= shreg_nxt;
        end
    end

    // Start re-check lands one cycle past the half-bit so a glitch shorter than
    // half a bit is rejected; every later sample is a whole bit further on.
    always_comb begin
        rx_state_nxt = rx_state;
        cnt_nxt      = cnt;
        bit_idx_nxt  = bit_idx;
        shreg_nxt    = shreg;
        byte_vld     = 1'b0;
        byte_ferr    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_s) begin
                    rx_state_nxt = RX_START;
                    cnt_nxt      = '0;
                end
            end
            RX_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_nxt      = '0;
                    bit_idx_nxt  = '0;
                    rx_state_nxt = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt     = '0;
                    shreg_nxt   = {rx_s, shreg[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) rx_state_nxt = RX_STOP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt == CNT_LAST) begin
                    byte_vld     = rx_s;
                    byte_ferr    = !rx_s;
                    cnt_nxt      = '0;
                    rx_state_nxt = RX_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    frm_state_t  state, state_nxt;
    logic [7:0]  len, len_nxt, word_idx, word_idx_nxt, csum, csum_nxt;
    logic [1:0]  byte_idx, byte_idx_nxt;
    logic [23:0] asm_word, asm_word_nxt;
    logic        we_q, we_nxt, hold_q, hold_nxt, done_q, done_nxt, err_q, err_nxt;
    logic [7:0]  addr_q, addr_nxt;
    logic [31:0] wdata_q, wdata_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= WAIT_SYNC;
            len      <= '0;
            word_idx <= '0;
            csum     <= '0;
            byte_idx <= '0;
            asm_word <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            hold_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            len      <= len_nxt;
            word_idx <= word_idx_nxt;
            csum     <= csum_nxt;
            byte_idx <= byte_idx_nxt;
            asm_word <= asm_word_nxt;
            we_q     <= we_nxt;
            addr_q   <= addr_nxt;
            wdata_q  <= wdata_nxt;
            hold_q   <= hold_nxt;
            done_q   <= done_nxt;
            err_q    <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        len_nxt      = len;
        word_idx_nxt = word_idx;
        csum_nxt     = csum;
        byte_idx_nxt = byte_idx;
        asm_word_nxt = asm_word;
        we_nxt       = 1'b0;
        addr_nxt     = addr_q;
        wdata_nxt    = wdata_q;
        hold_nxt     = hold_q;
        done_nxt     = done_q;
        err_nxt      = err_q;
        if (byte_ferr && state != WAIT_SYNC) begin
            err_nxt   = 1'b1;
            state_nxt = WAIT_SYNC;
        end else if (byte_vld) begin
            case (state)
                WAIT_SYNC: begin
                    if (shreg == SYNC) begin
                        done_nxt     = 1'b0;
                        err_nxt      = 1'b0;
                        hold_nxt     = 1'b1;
                        word_idx_nxt = '0;
                        byte_idx_nxt = '0;
                        csum_nxt     = '0;
                        state_nxt    = GET_LEN;
                    end
                end
                GET_LEN: begin
                    if (shreg == 8'd0 || shreg > LEN_MAX) begin
                        err_nxt   = 1'b1;
                        state_nxt = WAIT_SYNC;
                    end else begin
                        len_nxt   = shreg;
                        state_nxt = GET_DATA;
                    end
                end
                GET_DATA: begin
                    csum_nxt     = csum ^ shreg;
                    byte_idx_nxt = byte_idx + 2'd1;
                    case (byte_idx)
                        2'd0: asm_word_nxt[7:0]   = shreg;
                        2'd1: asm_word_nxt[15:8]  = shreg;
                        2'd2: asm_word_nxt[23:16] = shreg;
                        default: begin
                            we_nxt       = 1'b1;
                            addr_nxt     = {word_idx[5:0], 2'b00};
                            wdata_nxt    = {shreg, asm_word};
                            word_idx_nxt = word_idx + 8'd1;
                            if (word_idx == len - 8'd1) state_nxt = GET_CSUM;
                        end
                    endcase
                end
                GET_CSUM: begin
                    if (shreg == csum) begin
                        done_nxt = 1'b1;
                        hold_nxt = 1'b0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                    state_nxt = WAIT_SYNC;
                end
                default: state_nxt = WAIT_SYNC;
            endcase
        end
    end

    assign imem.imem_we    = we_q;
    assign imem.imem_addr  = addr_q;
    assign imem.imem_wdata = wdata_q;
    assign core_hold       = hold_q;
    assign done            = done_q;
    assign err             = err_q;
endmodule
